// File: rtl/riscv_id_ex_reg.sv
// ID/EX pipeline register for a RISC-V core.
// Holds one decoded instruction between decode and the ALU. Register operands
// are resolved against the EX/MEM and MEM/WB result buses when the instruction
// is captured. While the instruction is stalled, its operands keep being
// refreshed from those buses.
module riscv_id_ex_reg #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic [3:0]  in_alu_ctrl,
  input  logic        in_use_imm,
  input  logic        in_reg_write,
  input  logic        flush,
  input  logic        fwd_mem_valid,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_valid,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  rd_addr_o,
  output logic        reg_write_o,
  output logic [31:0] store_data_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_store_data;
  logic [3:0]  r_alu_ctrl;
  logic [4:0]  r_rd_addr;
  logic        r_reg_write;
  logic        r_use_imm;
  logic [4:0]  r_rs1_addr;
  logic [4:0]  r_rs2_addr;

  logic        w_capture;
  logic        w_snoop;
  logic [31:0] w_rs1_new;
  logic [31:0] w_rs2_new;
  logic [31:0] w_rs1_snoop;
  logic [31:0] w_rs2_snoop;

  // The MEM result is newer than the WB result, so it is checked first.
  // Register x0 is hardwired to zero and must never take a forwarded value.
  function automatic logic [31:0] resolve(
    input logic [4:0]  addr,
    input logic [31:0] rfData,
    input logic        memValid,
    input logic [4:0]  memRd,
    input logic [31:0] memData,
    input logic        wbValid,
    input logic [4:0]  wbRd,
    input logic [31:0] wbData
  );
    logic [31:0] result;
    result = rfData;
    if (addr != 5'd0 && memValid && memRd == addr)
      result = memData;
    else if (addr != 5'd0 && wbValid && wbRd == addr)
      result = wbData;
    return result;
  endfunction

  assign out_valid = (r_state == FULL);
  assign in_ready  = (!out_valid || out_ready) && !flush;
  assign w_capture = in_valid && in_ready;
  assign w_snoop   = (r_state == FULL) && !out_ready && !flush;

  // With forwarding disabled, operands come straight from the register file
  // and a stalled instruction keeps the values it was captured with.
  assign w_rs1_new   = FWD_EN ? resolve(in_rs1_addr, in_rs1_data, fwd_mem_valid, fwd_mem_rd,
                                        fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data)
                              : in_rs1_data;
  assign w_rs2_new   = FWD_EN ? resolve(in_rs2_addr, in_rs2_data, fwd_mem_valid, fwd_mem_rd,
                                        fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data)
                              : in_rs2_data;
  assign w_rs1_snoop = FWD_EN ? resolve(r_rs1_addr, r_alu_a, fwd_mem_valid, fwd_mem_rd,
                                        fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data)
                              : r_alu_a;
  assign w_rs2_snoop = FWD_EN ? resolve(r_rs2_addr, r_store_data, fwd_mem_valid, fwd_mem_rd,
                                        fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data)
                              : r_store_data;

  // Occupancy state register; reset discards any held instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= EMPTY;
    else
      r_state <= w_state_next;
  end

  // Next occupancy: flush empties the stage; a consumed entry is replaced
  // by a new one in the same cycle when decode offers it.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_capture) w_state_next = FULL;
        FULL:  if (out_ready) w_state_next = in_valid ? FULL : EMPTY;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // Payload: cleared by reset or flush, loaded on capture, refreshed from the
  // result buses while stalled, otherwise held. alu_b keeps the immediate
  // when the instruction uses one, even if rs2 is refreshed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_store_data <= 32'd0;
      r_alu_ctrl   <= 4'd0;
      r_rd_addr    <= 5'd0;
      r_reg_write  <= 1'b0;
      r_use_imm    <= 1'b0;
      r_rs1_addr   <= 5'd0;
      r_rs2_addr   <= 5'd0;
    end else if (flush) begin
      r_alu_a      <= 32'd0;
      r_alu_b      <= 32'd0;
      r_store_data <= 32'd0;
      r_alu_ctrl   <= 4'd0;
      r_rd_addr    <= 5'd0;
      r_reg_write  <= 1'b0;
      r_use_imm    <= 1'b0;
      r_rs1_addr   <= 5'd0;
      r_rs2_addr   <= 5'd0;
    end else if (w_capture) begin
      r_alu_a      <= w_rs1_new;
      r_alu_b      <= in_use_imm ? in_imm : w_rs2_new;
      r_store_data <= w_rs2_new;
      r_alu_ctrl   <= in_alu_ctrl;
      r_rd_addr    <= in_rd_addr;
      r_reg_write  <= in_reg_write;
      r_use_imm    <= in_use_imm;
      r_rs1_addr   <= in_rs1_addr;
      r_rs2_addr   <= in_rs2_addr;
    end else if (w_snoop) begin
      r_alu_a      <= w_rs1_snoop;
      r_store_data <= w_rs2_snoop;
      if (!r_use_imm)
        r_alu_b <= w_rs2_snoop;
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign store_data_o = r_store_data;
  assign alu_ctrl     = r_alu_ctrl;
  assign rd_addr_o    = r_rd_addr;
  assign reg_write_o  = r_reg_write;

endmodule

// File: tb/tb_riscv_id_ex_reg.sv
// Self-checking bench for riscv_id_ex_reg: directed scenarios followed by
// random traffic, all compared against an instruction-level reference model.
module tb_riscv_id_ex_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic [4:0]  in_rd_addr;
  logic [3:0]  in_alu_ctrl;
  logic        in_use_imm;
  logic        in_reg_write;
  logic        flush;
  logic        fwd_mem_valid;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_data;
  logic        fwd_wb_valid;
  logic [4:0]  fwd_wb_rd;
  logic [31:0] fwd_wb_data;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o;
  logic [31:0] store_data_o;

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model: the instruction currently held by the stage.
  logic        mValid;
  logic [31:0] mRs1;
  logic [31:0] mRs2;
  logic [4:0]  mA1;
  logic [4:0]  mA2;
  logic [31:0] mImm;
  logic        mUseImm;
  logic [3:0]  mCtrl;
  logic [4:0]  mRd;
  logic        mRw;

  riscv_id_ex_reg #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_ctrl(in_alu_ctrl), .in_use_imm(in_use_imm), .in_reg_write(in_reg_write),
    .flush(flush),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_ready(out_ready), .out_valid(out_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .store_data_o(store_data_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Value a register operand should take given the current result buses.
  function automatic logic [31:0] bypass(input logic [4:0] addr, input logic [31:0] fallback);
    if (addr == 0) return fallback;
    if (fwd_mem_valid && fwd_mem_rd == addr) return fwd_mem_data;
    if (fwd_wb_valid && fwd_wb_rd == addr) return fwd_wb_data;
    return fallback;
  endfunction

  task automatic modelClear();
    mValid = 0; mRs1 = 0; mRs2 = 0; mA1 = 0; mA2 = 0;
    mImm = 0; mUseImm = 0; mCtrl = 0; mRd = 0; mRw = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    logic accept;
    accept = (!mValid || out_ready) && !flush;
    if (flush) begin
      modelClear();
    end else if (in_valid && accept) begin
      mValid  = 1;
      mRs1    = bypass(in_rs1_addr, in_rs1_data);
      mRs2    = bypass(in_rs2_addr, in_rs2_data);
      mA1     = in_rs1_addr;
      mA2     = in_rs2_addr;
      mImm    = in_imm;
      mUseImm = in_use_imm;
      mCtrl   = in_alu_ctrl;
      mRd     = in_rd_addr;
      mRw     = in_reg_write;
    end else if (mValid && out_ready) begin
      mValid = 0;
    end else if (mValid) begin
      mRs1 = bypass(mA1, mRs1);
      mRs2 = bypass(mA2, mRs2);
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mValid});
    checkOutput("alu_a", alu_a, mRs1);
    checkOutput("alu_b", alu_b, mUseImm ? mImm : mRs2);
    checkOutput("store_data", store_data_o, mRs2);
    checkOutput("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, mCtrl});
    checkOutput("rd_addr", {27'd0, rd_addr_o}, {27'd0, mRd});
    checkOutput("reg_write", {31'd0, reg_write_o}, {31'd0, mRw});
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                               input logic useImm, input logic [3:0] ctrl, input logic oReady,
                               input logic fl);
    in_valid = valid; in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = useImm; in_alu_ctrl = ctrl; out_ready = oReady; flush = fl;
    in_rd_addr = 5'd9; in_reg_write = 1'b1;
  endtask

  task automatic setForward(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                            input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    fwd_mem_valid = mv; fwd_mem_rd = mrd; fwd_mem_data = md;
    fwd_wb_valid = wv; fwd_wb_rd = wrd; fwd_wb_data = wd;
  endtask

  // Called at a falling edge with inputs applied: checks in_ready, clocks the
  // DUT and the model, then checks every output at the next falling edge.
  task automatic stepCycle();
    #1;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!mValid || out_ready) && !flush});
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    modelClear();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    setForward(0, 0, 0, 0, 0, 0);
    #2;
    compareAll();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Capture with one cycle latency.
    applyStimulus(1, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 0, 4'b0000, 1, 0);
    stepCycle();
    checkOutput("cap_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("cap_a", alu_a, 32'd5);
    checkOutput("cap_b", alu_b, 32'd7);

    // Forwarding priority and x0 exclusion.
    setForward(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    applyStimulus(1, 5'd3, 32'h11, 5'd0, 32'h0, 32'd0, 0, 4'b0000, 1, 0);
    stepCycle();
    checkOutput("fwd_mem", alu_a, 32'hAA);
    setForward(0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    stepCycle();
    checkOutput("fwd_wb", alu_a, 32'hBB);
    setForward(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
    applyStimulus(1, 5'd0, 32'h11, 5'd0, 32'h0, 32'd0, 0, 4'b0000, 1, 0);
    stepCycle();
    checkOutput("fwd_x0", alu_a, 32'h11);

    // Stall with rs2 refreshed from the WB bus.
    setForward(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd1, 32'h1, 5'd4, 32'h55, 32'd0, 0, 4'b0000, 1, 0);
    stepCycle();
    applyStimulus(0, 5'd0, 32'h0, 5'd0, 32'h0, 32'd0, 0, 4'b0000, 0, 0);
    setForward(0, 0, 0, 1, 5'd4, 32'h1234);
    stepCycle();
    checkOutput("snoop_b", alu_b, 32'h1234);
    checkOutput("snoop_store", store_data_o, 32'h1234);
    checkOutput("snoop_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("snoop_ready", {31'd0, in_ready}, 32'd0);

    // Stall with immediate operand: alu_b must keep the immediate.
    setForward(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd1, 32'h1, 5'd4, 32'h55, 32'h10, 1, 4'b0000, 1, 0);
    stepCycle();
    applyStimulus(0, 5'd0, 32'h0, 5'd0, 32'h0, 32'd0, 0, 4'b0000, 0, 0);
    setForward(0, 0, 0, 1, 5'd4, 32'h1234);
    stepCycle();
    checkOutput("imm_b", alu_b, 32'h10);
    checkOutput("imm_store", store_data_o, 32'h1234);

    // Back-to-back stream without bubbles.
    setForward(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 0, 4'(k), 1, 0);
      stepCycle();
      checkOutput("b2b_ctrl", {28'd0, alu_ctrl}, k);
      checkOutput("b2b_valid", {31'd0, out_valid}, 32'd1);
    end

    // Flush beats an incoming instruction.
    applyStimulus(1, 5'd1, 32'd8, 5'd2, 32'd9, 32'd0, 0, 4'b0001, 1, 0);
    stepCycle();
    applyStimulus(1, 5'd1, 32'd8, 5'd2, 32'd9, 32'd0, 0, 4'b0010, 1, 1);
    #1 checkOutput("flush_ready", {31'd0, in_ready}, 32'd0);
    stepCycle();
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_ctrl", {28'd0, alu_ctrl}, 32'd0);
    checkOutput("flush_a", alu_a, 32'd0);

    // Asynchronous reset while full.
    applyStimulus(1, 5'd1, 32'd8, 5'd2, 32'd9, 32'd0, 0, 4'b0011, 1, 0);
    stepCycle();
    applyStimulus(0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 0, 4'b0000, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    modelClear();
    compareAll();
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 0, 4'b0000, 1, 0);
    stepCycle();
    checkOutput("rst_no_pulse", {31'd0, out_valid}, 32'd0);

    // Random traffic with a narrow register range to exercise forwarding.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
                    5'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 9)), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0);
      in_rd_addr = 5'($urandom_range(0, 31));
      in_reg_write = $urandom_range(0, 1) == 1;
      setForward($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/riscv_id_ex_reg.md
RISCV_ID_EX_REG -- requirements
Module: riscv_id_ex_reg

Interface
REQ-001 SHALL have parameter: FWD_EN, 1, enables operand forwarding (0 = register-file data used unmodified).
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decode stage holds a valid instruction.
- in_ready  out  1  this stage accepts input this cycle.
- in_rs1_data, in_rs2_data  in  32  register-file read data.
- in_imm  in  32  sign-extended immediate.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  5  register indices.
- in_alu_ctrl  in  4  ALU op code, ALU encoding (0000 ADD ... 1001 SLTU).
- in_use_imm  in  1  operand B = in_imm.
- in_reg_write  in  1  instruction writes rd.
- flush  in  1  synchronous kill of held and incoming instruction.
- fwd_mem_valid / fwd_mem_rd / fwd_mem_data  in  1/5/32  EX/MEM result bus.
- fwd_wb_valid / fwd_wb_rd / fwd_wb_data  in  1/5/32  MEM/WB result bus.
- out_ready  in  1  ALU stage accepts this cycle.
- out_valid  out  1  payload valid.
- alu_a, alu_b  out  32  ALU operands.
- alu_ctrl  out  4  ALU op code.
- rd_addr_o  out  5; reg_write_o  out  1; store_data_o  out  32 (forwarded rs2).

Function
REQ-003 SHALL be a single-entry register with two states: EMPTY (out_valid=0) and FULL (out_valid=1); all outputs registered except in_ready.
REQ-004 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-005 Capture SHALL occur when in_valid && in_ready; out_valid=1 and payload visible on the following cycle (latency 1).
REQ-006 EMPTY->FULL on capture; FULL->EMPTY when out_ready && !in_valid; FULL->FULL with new payload when out_ready && in_valid (back-to-back, no bubble).
REQ-007 FULL with out_ready=0 SHALL hold payload, except operand snooping (REQ-010).
REQ-008 Forwarding at capture (FWD_EN=1): rsN source = fwd_mem_data if fwd_mem_valid && fwd_mem_rd==rsN_addr && rsN_addr!=0; else fwd_wb_data if the same WB conditions hold; else in_rsN_data. MEM SHALL take priority over WB.
REQ-009 Index 0 SHALL never forward; x0 operand SHALL be the register-file value.
REQ-010 While FULL and not advancing, stored rs1/rs2 values SHALL be updated each cycle from the forward buses using REQ-008 priority against the stored rs addresses.
REQ-011 alu_a = resolved rs1; alu_b = in_use_imm ? in_imm : resolved rs2; store_data_o = resolved rs2 always; snooping SHALL NOT alter alu_b when use_imm is set.
REQ-012 flush=1 SHALL, on the next edge, set out_valid=0 and zero all payload outputs (alu_ctrl=0000); flush SHALL override capture and out_ready.
REQ-013 FWD_EN=0 SHALL disable REQ-008 and REQ-010.
REQ-014 Payload SHALL NOT change when out_valid=0 except by capture, flush or reset.

Reset
REQ-015 rst_n=0 SHALL immediately force out_valid=0 and alu_a, alu_b, store_data_o, alu_ctrl, rd_addr_o, reg_write_o and stored rs addresses to 0, independent of clk.
REQ-016 After release with flush=0, in_ready SHALL be 1; the first capture is permitted on the first rising edge after rst_n rises.
REQ-017 Reset asserted while FULL SHALL discard the instruction; no output pulse SHALL follow release.

Verification
REQ-018 Capture/latency: in_valid=1, rs1=5, rs2=7, use_imm=0, ctrl=0000, out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_ctrl=0000.
REQ-019 Forward priority: rs1_addr=3, fwd_mem{1,3,0xAA}, fwd_wb{1,3,0xBB}, in_rs1_data=0x11 -> alu_a=0xAA; repeat with fwd_mem_valid=0 -> 0xBB; rs1_addr=0 with both buses on rd=0 -> 0x11.
REQ-020 Stall+snoop: FULL, out_ready=0, rs2_addr=4, use_imm=0; cycle later fwd_wb{1,4,0x1234} -> alu_b=store_data_o=0x1234, out_valid held 1, in_ready=0; with use_imm=1, imm=0x10 -> alu_b stays 0x10, store_data_o=0x1234.
REQ-021 Back-to-back: in_valid=1, out_ready=1 for 4 cycles with ctrl 0000,0001,0010,0011 -> alu_ctrl shows each in order on consecutive cycles, out_valid continuously 1.
REQ-022 Flush: FULL with ctrl=0001 and in_valid=1, flush=1 -> in_ready=0 that cycle; next cycle out_valid=0, all payload 0, new instruction not captured.
REQ-023 Async reset: FULL, drop rst_n mid-cycle -> out_valid=0 and outputs 0 before next clk edge; release -> in_ready=1, out_valid stays 0 until a capture.
